// File: rtl/hdmi_axi_addr_gen.sv
// Frame-buffer read address generator: walks a frame line by line and issues
// burst read requests (byte address + pixel count), paced by line starts.
module hdmi_axi_addr_gen #(
  parameter int H_PIXELS        = 1280,
  parameter int V_LINES         = 720,
  parameter int BURST_WORDS     = 64,
  parameter int BYTES_PER_PIXEL = 4,
  parameter int ADDR_W          = 32
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic              prefetch_line,
  input  logic [1:0]        pixelena_edge,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [ADDR_W-1:0] line_stride,
  input  logic              busy,
  output logic              kick,
  output logic [ADDR_W-1:0] read_addr,
  output logic [8:0]        read_num,
  output logic              frame_done,
  output logic              line_overrun
);
  // state     | meaning
  // IDLE      | no frame active, waiting for prefetch_line
  // WAIT      | next request is prepared once busy drops
  // ISSUE     | kick high, request held until busy=1 accepts it
  // LINE_DONE | line fully issued, waiting for a line start (2'b01)
  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, LINE_DONE} state_t;

  state_t            state_q;
  logic [11:0]       x_cnt_q;
  logic [11:0]       y_cnt_q;
  logic [ADDR_W-1:0] line_base_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] addr_q;
  logic [8:0]        num_q;
  logic              kick_q;
  logic              frame_done_q;
  logic              overrun_q;

  logic [12:0]       remain;
  logic [ADDR_W-1:0] addr_d;
  logic [8:0]        num_d;
  logic [12:0]       x_end;
  logic [12:0]       y_next;
  logic              line_start;

  always_comb begin
    remain     = 13'(H_PIXELS) - {1'b0, x_cnt_q};
    num_d      = (remain > 13'(BURST_WORDS)) ? 9'(BURST_WORDS) : remain[8:0];
    addr_d     = line_base_q + ADDR_W'(x_cnt_q) * ADDR_W'(BYTES_PER_PIXEL);
    x_end      = {1'b0, x_cnt_q} + {4'b0000, num_q};
    y_next     = {1'b0, y_cnt_q} + 13'd1;
    line_start = (pixelena_edge == 2'b01);
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      line_base_q  <= '0;
      stride_q     <= '0;
      addr_q       <= '0;
      num_q        <= '0;
      kick_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (prefetch_line) begin
            line_base_q <= frame_base;
            stride_q    <= line_stride;
            x_cnt_q     <= '0;
            y_cnt_q     <= '0;
            overrun_q   <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (line_start) overrun_q <= 1'b1;
          if (!busy) begin
            addr_q  <= addr_d;
            num_q   <= num_d;
            kick_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // a line start here is only flagged; the request in flight is untouched
          if (line_start) overrun_q <= 1'b1;
          if (busy) begin
            kick_q <= 1'b0;
            if (x_end == 13'(H_PIXELS)) begin
              x_cnt_q     <= '0;
              y_cnt_q     <= y_next[11:0];
              line_base_q <= line_base_q + stride_q;
              if (y_next == 13'(V_LINES)) begin
                state_q      <= IDLE;
                frame_done_q <= 1'b1;
              end else begin
                state_q <= LINE_DONE;
              end
            end else begin
              x_cnt_q <= x_end[11:0];
              state_q <= WAIT;
            end
          end
        end
        LINE_DONE: begin
          if (line_start) state_q <= WAIT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kick         = kick_q;
  assign read_addr    = addr_q;
  assign read_num     = num_q;
  assign frame_done   = frame_done_q;
  assign line_overrun = overrun_q;

endmodule

// File: tb/tb_hdmi_axi_addr_gen.sv
// Bench for hdmi_axi_addr_gen: a frame-table of fixed cases, random frames
// checked against a request-list model, and hand-built corner sequences.
module tb_hdmi_axi_addr_gen;
  localparam int H   = 200;
  localparam int V   = 3;
  localparam int B   = 64;
  localparam int BPP = 4;
  localparam int RPL = (H + B - 1) / B;

  logic        clk_vga = 1'b0;
  logic        rst_n = 1'b0;
  logic        prefetch_line = 1'b0;
  logic [1:0]  pixelena_edge = 2'b00;
  logic [31:0] frame_base = '0;
  logic [31:0] line_stride = '0;
  logic        busy = 1'b0;
  logic        kick;
  logic [31:0] read_addr;
  logic [8:0]  read_num;
  logic        frame_done;
  logic        line_overrun;

  hdmi_axi_addr_gen #(
    .H_PIXELS(H), .V_LINES(V), .BURST_WORDS(B), .BYTES_PER_PIXEL(BPP), .ADDR_W(32)
  ) dut (
    .clk_vga(clk_vga), .rst_n(rst_n), .prefetch_line(prefetch_line),
    .pixelena_edge(pixelena_edge), .frame_base(frame_base), .line_stride(line_stride),
    .busy(busy), .kick(kick), .read_addr(read_addr), .read_num(read_num),
    .frame_done(frame_done), .line_overrun(line_overrun)
  );

  typedef struct {
    logic [31:0] addr;
    logic [8:0]  num;
    bit          last;
  } req_t;

  typedef struct {
    logic [31:0] base;
    logic [31:0] stride;
    logic [31:0] second;
    logic [31:0] last;
    logic [8:0]  last_num;
    int          count;
  } vec_t;

  req_t        exp_q[$];
  req_t        hd;
  logic [31:0] obs_addr[$];
  logic [8:0]  obs_num[$];
  vec_t        vt[4];

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;
  int busy_mode = 0;
  bit mon_en = 1'b0;
  bit no_kick = 1'b0;
  bit fd_pend = 1'b0;
  bit prev_kick = 1'b0;
  bit prev_acc = 1'b0;

  initial forever #5 clk_vga = ~clk_vga;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // busy: 0 = random, 1 = held high, 2 = held low
  initial forever begin
    @(posedge clk_vga);
    #2;
    case (busy_mode)
      0:       busy = 1'($urandom_range(0, 1));
      1:       busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected request list for one frame, straight from the addressing rules
  function automatic void build_frame(input logic [31:0] base, input logic [31:0] stride);
    int   x;
    int   n;
    req_t r;
    for (int y = 0; y < V; y++) begin
      x = 0;
      while (x < H) begin
        n = (H - x < B) ? (H - x) : B;
        r.addr = base + 32'(y) * stride + 32'(x * BPP);
        r.num  = 9'(n);
        r.last = (y == V - 1) && (x + n == H);
        exp_q.push_back(r);
        x += n;
      end
    end
  endfunction

  initial forever begin
    @(negedge clk_vga);
    if (mon_en) begin
      check("frame_done", frame_done, fd_pend);
      fd_pend = 1'b0;
      if (no_kick) check("kick_gated", kick, 1'b0);
      if (prev_kick && !prev_acc) check("kick_held", kick, 1'b1);
      if (kick) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_req: got addr %0h, no request expected", read_addr);
        end else begin
          hd = exp_q[0];
          check("req_addr", read_addr, hd.addr);
          check("req_num", read_num, hd.num);
          if (busy) begin
            void'(exp_q.pop_front());
            fd_pend = hd.last;
          end
        end
        if (busy) begin
          obs_addr.push_back(read_addr);
          obs_num.push_back(read_num);
          acc_cnt++;
        end
      end
      prev_kick = kick;
      prev_acc  = kick && busy;
    end
  end

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic wait_acc(input int target);
    int guard = 0;
    while (acc_cnt < target && guard < 500) begin
      tick();
      guard++;
    end
    if (acc_cnt < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_accept: got %0d accepts expected %0d", acc_cnt, target);
    end
  endtask

  task automatic wait_kick();
    int guard = 0;
    while (kick !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (kick !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_kick: got kick=%b expected 1", kick);
    end
  endtask

  task automatic start_frame(input logic [31:0] base, input logic [31:0] stride);
    build_frame(base, stride);
    obs_addr.delete();
    obs_num.delete();
    acc_cnt       = 0;
    frame_base    = base;
    line_stride   = stride;
    prefetch_line = 1'b1;
    no_kick       = 1'b0;
    tick();
    prefetch_line = 1'b0;
    frame_base    = $urandom;
    line_stride   = $urandom;
  endtask

  task automatic finish_frame(input bit poke_prefetch);
    int k;
    for (int y = 0; y < V; y++) begin
      wait_acc((y + 1) * RPL);
      if (y < V - 1) begin
        no_kick = 1'b1;
        repeat (3) begin
          k = $urandom_range(0, 2);
          pixelena_edge = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : 2'b11;
          prefetch_line = poke_prefetch;
          tick();
        end
        prefetch_line = 1'b0;
        pixelena_edge = 2'b01;
        tick();
        pixelena_edge = 2'b00;
        no_kick = 1'b0;
      end
    end
    no_kick = 1'b1;
    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    vt[0] = '{32'h1000_0000, 32'h0000_0400, 32'h1000_0100, 32'h1000_0B00, 9'd8, V * RPL};
    vt[1] = '{32'hFFFF_FF00, 32'h0000_0400, 32'h0000_0000, 32'h0000_0A00, 9'd8, V * RPL};
    vt[2] = '{32'h2000_0000, 32'hFFFF_F000, 32'h2000_0100, 32'h1FFF_E300, 9'd8, V * RPL};
    vt[3] = '{32'h0000_0040, 32'h0000_0000, 32'h0000_0140, 32'h0000_0340, 9'd8, V * RPL};

    repeat (3) @(posedge clk_vga);
    #1;
    check("rst_kick", kick, 1'b0);
    check("rst_addr", read_addr, 32'h0);
    check("rst_num", read_num, 9'h0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overrun", line_overrun, 1'b0);
    rst_n   = 1'b1;
    mon_en  = 1'b1;
    no_kick = 1'b1;
    repeat (10) tick();

    for (int i = 0; i < 4; i++) begin
      start_frame(vt[i].base, vt[i].stride);
      finish_frame(i == 0);
      check("t_count", obs_addr.size(), vt[i].count);
      if (obs_addr.size() >= 2) begin
        check("t_first", obs_addr[0], vt[i].base);
        check("t_second", obs_addr[1], vt[i].second);
        check("t_last", obs_addr[$], vt[i].last);
        check("t_last_num", obs_num[$], vt[i].last_num);
      end
      check("t_overrun", line_overrun, 1'b0);
    end

    // ISSUE held under busy=0 with a stray line start, then WAIT held under busy=1
    busy_mode = 2;
    start_frame(32'h3000_0000, 32'h0000_1000);
    wait_kick();
    pixelena_edge = 2'b01;
    tick();
    pixelena_edge = 2'b00;
    repeat (10) tick();
    check("bp_kick_issue", kick, 1'b1);
    busy_mode = 1;
    tick();
    tick();
    no_kick = 1'b1;
    repeat (10) tick();
    check("bp_kick_wait", kick, 1'b0);
    check("ovr_set", line_overrun, 1'b1);
    no_kick   = 1'b0;
    busy_mode = 0;
    finish_frame(1'b0);
    check("ovr_sticky", line_overrun, 1'b1);
    start_frame(32'h4000_0000, 32'h0000_0800);
    check("ovr_cleared", line_overrun, 1'b0);
    finish_frame(1'b0);

    for (int i = 0; i < 5; i++) begin
      start_frame($urandom, $urandom);
      finish_frame(1'($urandom_range(0, 1)));
    end

    // reset while a request is on the bus
    busy_mode = 2;
    start_frame($urandom, $urandom);
    wait_kick();
    pixelena_edge = 2'b01;
    tick();
    pixelena_edge = 2'b00;
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_rst_kick", kick, 1'b0);
    check("mid_rst_addr", read_addr, 32'h0);
    check("mid_rst_num", read_num, 9'h0);
    check("mid_rst_overrun", line_overrun, 1'b0);
    check("mid_rst_frame_done", frame_done, 1'b0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    fd_pend   = 1'b0;
    prev_kick = 1'b0;
    prev_acc  = 1'b0;
    busy_mode = 0;
    no_kick   = 1'b1;
    mon_en    = 1'b1;
    repeat (20) tick();
    check("post_rst_kick", kick, 1'b0);
    start_frame(32'h5000_0000, 32'h0000_0C80);
    finish_frame(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
